// File: rtl/hbuf_rdout_feeder.sv
// Waveform packet feeder for the hit buffer readout DPRAM.
// Packs a 16-bit packet word stream into 32-bit DPRAM words, pads odd-length
// packets with one zero word, then hands the packet over with a run/busy handshake.
`timescale 1ns / 1ps

module hbuf_rdout_feeder #(
    parameter int unsigned MAX_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic [15:0] i_in_data,
    input  logic        i_in_valid,
    input  logic        i_in_sop,
    input  logic        i_in_eop,
    output logic        o_in_ready,
    output logic        o_dpram_wren,
    output logic [9:0]  o_dpram_wr_addr,
    output logic [31:0] o_dpram_data,
    output logic [15:0] o_dpram_len,
    output logic        o_dpram_run,
    input  logic        i_dpram_busy,
    output logic [31:0] o_pkt_cnt,
    output logic [15:0] o_drop_cnt,
    output logic        o_trunc_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_PAD,
        S_RUN,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam logic [11:0] MAX_CNT = 12'(MAX_WORDS);

    state_t      r_state;
    logic        r_rdy;
    logic [15:0] r_lo;
    logic [11:0] r_cnt;
    logic        r_wren;
    logic [9:0]  r_addr;
    logic [31:0] r_data;
    logic [15:0] r_len;
    logic        r_run;
    logic [31:0] r_pkt;
    logic [15:0] r_drop;
    logic        r_trunc;

    // A sop arriving mid-packet closes the current packet and is held off until
    // the hand-off completes, so it becomes the first word of the next packet.
    logic        w_hold;
    logic        w_accept;
    logic        w_full;
    logic [11:0] w_cnt_inc;

    assign w_hold     = (r_state == S_FILL) && i_in_valid && i_in_sop;
    assign o_in_ready = r_rdy && !w_hold;
    assign w_accept   = i_in_valid && o_in_ready;
    assign w_full     = (r_cnt == MAX_CNT);
    assign w_cnt_inc  = r_cnt + 12'd1;

    // Packet fill / pad / hand-off state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            r_state <= S_IDLE;
            r_rdy   <= 1'b0;
            r_lo    <= 16'h0000;
            r_cnt   <= 12'd0;
            r_wren  <= 1'b0;
            r_addr  <= 10'd0;
            r_data  <= 32'h0000_0000;
            r_len   <= 16'h0000;
            r_run   <= 1'b0;
            r_pkt   <= 32'd0;
            r_drop  <= 16'h0000;
            r_trunc <= 1'b0;
        end else begin
            r_wren <= 1'b0;
            r_run  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_rdy <= 1'b1;
                    if (w_accept) begin
                        if (i_in_sop) begin
                            r_lo  <= i_in_data;
                            r_cnt <= 12'd1;
                            if (i_in_eop) begin
                                r_state <= S_PAD;
                                r_rdy   <= 1'b0;
                            end else begin
                                r_state <= S_FILL;
                            end
                        end else if (r_drop != 16'hFFFF) begin
                            r_drop <= r_drop + 16'd1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_hold) begin
                        // Odd count means the last word is an unpaired low half.
                        r_state <= r_cnt[0] ? S_PAD : S_RUN;
                        r_rdy   <= 1'b0;
                    end else if (w_accept) begin
                        // Once full, words up to eop are accepted but dropped.
                        if (!w_full) begin
                            r_cnt <= w_cnt_inc;
                            if (r_cnt[0]) begin
                                r_wren <= 1'b1;
                                r_data <= {i_in_data, r_lo};
                                r_addr <= r_cnt[10:1];
                            end else begin
                                r_lo <= i_in_data;
                            end
                            if ((w_cnt_inc == MAX_CNT) && !i_in_eop) begin
                                r_trunc <= 1'b1;
                            end
                        end
                        if (i_in_eop) begin
                            r_state <= (r_cnt[0] || w_full) ? S_RUN : S_PAD;
                            r_rdy   <= 1'b0;
                        end
                    end
                end
                S_PAD: begin
                    r_wren  <= 1'b1;
                    r_data  <= {16'h0000, r_lo};
                    r_addr  <= r_cnt[10:1];
                    r_cnt   <= w_cnt_inc;
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    r_run   <= 1'b1;
                    r_len   <= {4'h0, r_cnt};
                    r_pkt   <= r_pkt + 32'd1;
                    r_state <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    // Ignore busy during the run cycle itself.
                    if (!r_run && i_dpram_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_dpram_busy) begin
                        r_cnt   <= 12'd0;
                        r_addr  <= 10'd0;
                        r_state <= S_IDLE;
                        r_rdy   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_rdy   <= 1'b0;
                end
            endcase
        end
    end

    assign o_dpram_wren    = r_wren;
    assign o_dpram_wr_addr = r_addr;
    assign o_dpram_data    = r_data;
    assign o_dpram_len     = r_len;
    assign o_dpram_run     = r_run;
    assign o_pkt_cnt       = r_pkt;
    assign o_drop_cnt      = r_drop;
    assign o_trunc_err     = r_trunc;

endmodule

// File: doc/hbuf_rdout_feeder.md
# hbuf_rdout_feeder

Upstream stage of the mDOM hit buffer controller. It accepts waveform packets as a 16-bit word stream from the waveform-buffer reader arbiter and packs word pairs into 32-bit words. It writes one complete packet into the controller's 1024 x 32 readout DPRAM, then hands the packet over with the run/busy handshake. Odd-length packets get one 0x0000 filler word, so every hand-off is an even number of 16-bit words.

## Interface
Parameters:
- MAX_WORDS, 2048: maximum padded packet length in 16-bit words; equals DPRAM capacity of 1024 x 32.

Ports:
- clk  in  1  system clock; same clock as the hit buffer controller.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  enable; low acts as a synchronous reset of the FSM and counters.
- in_data  in  16  waveform packet word.
- in_valid  in  1  in_data valid.
- in_sop  in  1  first word of a packet; qualified by in_valid.
- in_eop  in  1  last word of a packet; qualified by in_valid.
- in_ready  out  1  word accepted when in_valid && in_ready.
- dpram_wren  out  1  DPRAM write enable.
- dpram_wr_addr  out  10  DPRAM write address.
- dpram_data  out  32  DPRAM write data; the first word of a pair goes in [15:0].
- dpram_len  out  16  padded packet length in 16-bit words; held stable from run until done.
- dpram_run  out  1  one-cycle hand-off strobe.
- dpram_busy  in  1  controller is consuming the DPRAM.
- pkt_cnt  out  32  packets handed off; wraps.
- drop_cnt  out  16  words discarded outside a packet; saturates at 0xFFFF.
- trunc_err  out  1  sticky: a packet exceeded MAX_WORDS.

## Operation
- FSM states: S_IDLE, S_FILL, S_PAD, S_RUN, S_WAIT_BUSY, S_WAIT_DONE.
- S_IDLE (in_ready=1):
  - A valid word with in_sop=0 is discarded and drop_cnt increments.
  - A valid word with in_sop=1 is stored as the low half, word count becomes 1, and the FSM goes to S_FILL.
  - If that same word also has in_eop=1, the FSM goes to S_PAD instead.
- S_FILL (in_ready=1):
  - Each accepted word alternates between low half and high half; the count increments.
  - On a high-half word: dpram_wren=1, data={hi,lo}, the address increments after the write; the first pair is written at address 0.
  - in_sop=1 mid-packet: the current packet is closed as if the previous word carried eop, and the sop word is held off (in_ready drops that cycle) so it starts the next packet after hand-off.
  - eop on a high-half word goes to S_RUN; eop on a low-half word goes to S_PAD.
- S_PAD: writes {16'h0000, lo}, adds 1 to the count, then goes to S_RUN.
- Truncation: when the count reaches MAX_WORDS without eop, trunc_err is set. Remaining words up to and including eop are accepted and discarded (not written). The 2048-word packet is then handed off.
- S_RUN:
  - dpram_run=1 for one cycle.
  - dpram_len = final padded count.
  - pkt_cnt increments.
  - Next state S_WAIT_BUSY.
- S_WAIT_BUSY: waits for dpram_busy=1.
- S_WAIT_DONE: waits for dpram_busy=0, then clears the address and count and returns to S_IDLE.
- in_ready=0 in S_PAD, S_RUN, S_WAIT_BUSY and S_WAIT_DONE. The DPRAM is never written while a hand-off is outstanding.
- Width rules: the count is 12 bits internally and zero-extended into dpram_len. The address is count>>1 before write.

## Timing
- Reset/en-low values: in_ready=0, dpram_wren=0, dpram_wr_addr=0, dpram_data=0, dpram_len=0, dpram_run=0, pkt_cnt=0, drop_cnt=0, trunc_err=0, FSM=S_IDLE.
- in_ready is 1 in S_IDLE on the first cycle after reset release with en=1.
- DPRAM writes are registered: the write for a high-half word is issued the cycle after acceptance.
- dpram_run is asserted two cycles after eop acceptance when no pad is needed, and three cycles after when a pad is needed.
- Hand-off timing:
  - The controller raises busy the cycle after run.
  - busy high is sampled no earlier than the cycle after run.
  - Earliest in_ready after busy falls: the cycle after busy is sampled low.
- Reset or en falling mid-packet or mid-hand-off: the FSM returns to S_IDLE immediately, dpram_run is forced low, and the partial packet is lost. No hand-off issues until a new sop arrives.
- dpram_len holds its value from S_RUN until the next S_RUN or reset.

## Test plan
- 4-word packet 0x1111, 0x2222, 0x3333, 0x4444 -> writes addr0=0x22221111 and addr1=0x44443333; run with len=4; pkt_cnt=1.
- 5-word packet -> addr2=0x0000_<w4>, len=6; the bench's hbuf model returns busy, and in_ready returns only after busy falls.
- Two words without sop, then a packet -> drop_cnt=2, and the packet is handed off intact from address 0.
- 2050-word packet -> trunc_err=1, len=2048, last write at addr 1023, words 2049–2050 discarded.
- sop arriving mid-packet after 3 words -> first hand-off len=4 (padded); the second packet starts at addr0 with the held sop word.
- rst asserted during S_WAIT_DONE -> all outputs at reset values the next cycle; the following packet hands off normally.
